// File: rtl/apb4_modport_if.sv
// APB4 bus bundle shared by the apb4_modport peripheral and its master.
// Clock and reset are not part of the bundle; they stay plain ports.
interface apb4_modport_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_modport.sv
// APB4 slave: seven RW registers (0x00-0x18) plus a read-only ID word (0x1C),
// programmable wait states and error response for bad addresses.
// Optional protocol checker enabled by defining APB4_MODPORT_PROT_CHECK_EN;
// without it proto_err is tied low and everything else behaves the same.
module apb4_modport #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,  // only 32 is supported
  parameter int                    WAIT_STATES = 0,   // 0..15
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA4B4_0001
) (
  input  logic           pclk,
  input  logic           presetn,
  apb4_modport_if.slave  bus,
  output logic           proto_err
);

  // ST_IDLE also covers "just completed": a new transfer must start with SETUP.
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);
  localparam logic [2:0] ID_IDX     = 3'd7;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] regs [7];
  logic [DATA_WIDTH-1:0] rd_val;
  logic [2:0]            idx;
  logic                  in_range;
  logic                  addr_err;
  logic                  access;
  logic                  ready;
  logic                  wr_en;

  assign idx      = bus.paddr[4:2];
  assign in_range = (bus.paddr[ADDR_WIDTH-1:5] == '0) && (bus.paddr[1:0] == 2'b00);
  assign addr_err = !in_range || (bus.pwrite && (idx == ID_IDX));
  // An ACCESS cycle only counts once a SETUP has been seen for this transfer.
  assign access   = bus.psel && bus.penable && (state != ST_IDLE);
  assign ready    = presetn && access && (wait_cnt == WAIT_LIMIT);
  assign wr_en    = ready && bus.pwrite && !addr_err;

  // State register for the tracked bus phase.
  always_ff @(posedge pclk or negedge presetn) begin
    // NOTE: flops are updated with <= so every register samples pre-edge values.
    if (!presetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next phase from the bus strobes; a completed transfer returns to IDLE.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (!bus.psel)               state_nxt = ST_IDLE;
    else if (!bus.penable)       state_nxt = ST_SETUP;
    else if (state == ST_IDLE)   state_nxt = ST_IDLE;
    else if (ready)              state_nxt = ST_IDLE;
    else                         state_nxt = ST_ACCESS;
  end

  // Response outputs; all zero outside the completing cycle and during reset.
  always_comb begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    if (ready) begin
      bus.pready  = 1'b1;
      bus.pslverr = addr_err;
      if (!bus.pwrite && !addr_err) bus.prdata = rd_val;
    end
  end

  // Read mux over the register file and the ID word.
  always_comb begin
    rd_val = ID_VALUE;
    for (int i = 0; i < 7; i++) begin
      if (idx == 3'(i)) rd_val = regs[i];
    end
  end

  // Wait counter: counts stalled ACCESS cycles, clears otherwise.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)              wait_cnt <= '0;
    else if (access && !ready) wait_cnt <= wait_cnt + 4'd1;
    else                       wait_cnt <= '0;
  end

  // Register file: commits only on an error-free completing write.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      // NOTE: seven words of flops, not a RAM, so each entry takes the async reset.
      for (int i = 0; i < 7; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (wr_en && (idx == 3'(i))) regs[i] <= bus.pwdata;
      end
    end
  end

`ifdef APB4_MODPORT_PROT_CHECK_EN
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  violation;

  // Capture the transfer attributes presented in SETUP.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else if (bus.psel && !bus.penable) begin
      cap_addr  <= bus.paddr;
      cap_write <= bus.pwrite;
      cap_wdata <= bus.pwdata;
    end
  end

  // Flag ACCESS without SETUP, SETUP not followed by ACCESS, or unstable inputs.
  always_comb begin
    violation = 1'b0;
    if (bus.psel && bus.penable && (state == ST_IDLE))      violation = 1'b1;
    if ((state == ST_SETUP) && !(bus.psel && bus.penable)) violation = 1'b1;
    if (access && ((bus.paddr != cap_addr) || (bus.pwrite != cap_write) ||
                   (bus.pwdata != cap_wdata)))              violation = 1'b1;
  end

  // Sticky flag, cleared only by reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)       proto_err <= 1'b0;
    else if (violation) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_modport.sv
// Bench for apb4_modport: two instances (0 and 3 wait states) driven by a
// transfer task; a reference model predicts each response into a queue and
// a negedge monitor pops and compares whenever pready is seen.
module tb_apb4_modport;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          WS0 = 0;
  localparam int          WS1 = 3;
  localparam logic [31:0] ID  = 32'hA4B4_0001;
`ifdef APB4_MODPORT_PROT_CHECK_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic        d_psel [2];
  logic        d_penable [2];
  logic        d_pwrite [2];
  logic [31:0] d_paddr [2];
  logic [31:0] d_pwdata [2];
  logic        r_pready [2];
  logic        r_pslverr [2];
  logic [31:0] r_prdata [2];
  logic        proto [2];

  apb4_modport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb4_modport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.psel    = d_psel[0];
  assign bus0.penable = d_penable[0];
  assign bus0.pwrite  = d_pwrite[0];
  assign bus0.paddr   = d_paddr[0];
  assign bus0.pwdata  = d_pwdata[0];
  assign bus1.psel    = d_psel[1];
  assign bus1.penable = d_penable[1];
  assign bus1.pwrite  = d_pwrite[1];
  assign bus1.paddr   = d_paddr[1];
  assign bus1.pwdata  = d_pwdata[1];
  assign r_pready[0]  = bus0.pready;
  assign r_pslverr[0] = bus0.pslverr;
  assign r_prdata[0]  = bus0.prdata;
  assign r_pready[1]  = bus1.pready;
  assign r_pslverr[1] = bus1.pslverr;
  assign r_prdata[1]  = bus1.prdata;

  apb4_modport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS0), .ID_VALUE(ID)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .bus(bus0), .proto_err(proto[0]));
  apb4_modport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS1), .ID_VALUE(ID)) u_dut1 (
    .pclk(pclk), .presetn(presetn), .bus(bus1), .proto_err(proto[1]));

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model [2][7];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          lat [2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic int ws_of(int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Reference behaviour: byte address below 32 and word aligned is a valid
  // word; word 7 is the ID (read-only), words 0..6 are storage.
  task automatic predict(int d, logic [31:0] addr, logic wr, logic [31:0] data, output exp_t e);
    int n;
    e.wr = wr;
    e.err = 1'b0;
    e.rdata = 32'h0;
    n = int'(addr / 4);
    if (addr >= 32 || (addr % 4) != 0 || (wr && n == 7)) e.err = 1'b1;
    else if (wr) model[d][n] = data;
    else if (n == 7) e.rdata = ID;
    else e.rdata = model[d][n];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 7; i++) model[d][i] = 32'h0;
  endtask

  // One APB transfer; abort_after>0 drops psel after that many ACCESS cycles.
  task automatic transfer(int d, logic [31:0] addr, logic wr, logic [31:0] data, int abort_after);
    exp_t e;
    bit   done;
    d_psel[d]    = 1'b1;
    d_penable[d] = 1'b0;
    d_paddr[d]   = addr;
    d_pwrite[d]  = wr;
    d_pwdata[d]  = data;
    tick();
    d_penable[d] = 1'b1;
    if (abort_after > 0) begin
      repeat (abort_after) tick();
    end else begin
      predict(d, addr, wr, data, e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        #1;
        if (r_pready[d]) done = 1'b1;
        tick();
      end
      check($sformatf("dut%0d handshake", d), 32'(done), 32'd1);
    end
    d_psel[d]    = 1'b0;
    d_penable[d] = 1'b0;
  endtask

  // Monitor: pops the expected response at each completing cycle.
  always @(negedge pclk) begin
    exp_t e;
    if (!presetn) begin
      lat[0] = 0;
      lat[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (d_psel[d] && d_penable[d]) begin
          lat[d]++;
          if (r_pready[d]) begin
            if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
              n_vec++;
              n_miss++;
              $display("FAIL dut%0d spurious pready: got 1, expected 0 (t=%0t)", d, $time);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("dut%0d prdata", d), r_prdata[d], e.rdata);
              check($sformatf("dut%0d pslverr", d), 32'(r_pslverr[d]), 32'(e.err));
              check($sformatf("dut%0d latency", d), 32'(lat[d]), 32'(ws_of(d) + 1));
            end
            lat[d] = 0;
          end
        end else begin
          lat[d] = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic        wr;
    int          d;
    int          ab;
    for (int i = 0; i < 2; i++) begin
      d_psel[i] = 1'b0; d_penable[i] = 1'b0; d_pwrite[i] = 1'b0;
      d_paddr[i] = 32'h0; d_pwdata[i] = 32'h0;
    end
    model_reset();

    // Reset state.
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dut%0d pready", i), 32'(r_pready[i]), 32'd0);
      check($sformatf("reset dut%0d pslverr", i), 32'(r_pslverr[i]), 32'd0);
      check($sformatf("reset dut%0d prdata", i), r_prdata[i], 32'h0);
      check($sformatf("reset dut%0d proto_err", i), 32'(proto[i]), 32'd0);
    end
    presetn = 1'b1;
    tick();

    // Directed: RW register, ID register, bad addresses, full readback.
    for (int i = 0; i < 2; i++) begin
      transfer(i, 32'h04, 1'b1, 32'h1234_5678, 0);
      transfer(i, 32'h04, 1'b0, 32'h0, 0);
      transfer(i, 32'h1C, 1'b0, 32'h0, 0);
      transfer(i, 32'h1C, 1'b1, 32'hFFFF_FFFF, 0);
      transfer(i, 32'h1C, 1'b0, 32'h0, 0);
      transfer(i, 32'h20, 1'b1, 32'hDEAD_BEEF, 0);
      transfer(i, 32'h02, 1'b1, 32'hCAFE_F00D, 0);
      transfer(i, 32'h20, 1'b0, 32'h0, 0);
      transfer(i, 32'h02, 1'b0, 32'h0, 0);
      for (int r = 0; r < 7; r++) transfer(i, 32'(r * 4), 1'b0, 32'h0, 0);
    end

    // Abort mid-ACCESS on the wait-state instance leaves the register alone.
    transfer(1, 32'h08, 1'b1, 32'h1111_1111, 0);
    transfer(1, 32'h08, 1'b1, 32'h2222_2222, WS1);
    tick();
    transfer(1, 32'h08, 1'b0, 32'h0, 0);

    // Randomised traffic, with back-to-back transfers when the gap is 0.
    for (int n = 0; n < 300; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       addr = 32'h20 + 4 * $urandom_range(0, 55);
        1:       addr = (4 * $urandom_range(0, 7)) | $urandom_range(1, 3);
        2:       begin addr = $urandom; addr[31] = 1'b1; end
        default: addr = 4 * $urandom_range(0, 7);
      endcase
      ab = (d == 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, WS1)) : 0;
      transfer(d, addr, wr, $urandom, ab);
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d proto_err after legal traffic", i), 32'(proto[i]), 32'd0);

    // Reset in the middle of a write ACCESS.
    transfer(0, 32'h00, 1'b1, 32'hA5A5_A5A5, 0);
    transfer(1, 32'h00, 1'b1, 32'hA5A5_A5A5, 0);
    transfer(1, 32'h00, 1'b0, 32'h0, 0);
    d_psel[1] = 1'b1; d_penable[1] = 1'b0; d_paddr[1] = 32'h0;
    d_pwrite[1] = 1'b1; d_pwdata[1] = 32'h5A5A_5A5A;
    tick();
    d_penable[1] = 1'b1;
    tick();
    #2 presetn = 1'b0;
    #1;
    check("mid-reset pready", 32'(r_pready[1]), 32'd0);
    check("mid-reset pslverr", 32'(r_pslverr[1]), 32'd0);
    check("mid-reset prdata", r_prdata[1], 32'h0);
    check("mid-reset proto_err", 32'(proto[1]), 32'd0);
    tick();
    d_psel[1] = 1'b0; d_penable[1] = 1'b0;
    tick();
    presetn = 1'b1;
    model_reset();
    tick();
    transfer(0, 32'h00, 1'b0, 32'h0, 0);
    transfer(1, 32'h00, 1'b0, 32'h0, 0);

    // ACCESS with no SETUP: no completion, sticky proto_err when checker built in.
    d_psel[0] = 1'b1; d_penable[0] = 1'b1; d_paddr[0] = 32'h04; d_pwrite[0] = 1'b0;
    #1;
    check("no-setup pready", 32'(r_pready[0]), 32'd0);
    tick();
    check("no-setup proto_err", 32'(proto[0]), 32'(PROT));
    d_psel[0] = 1'b0; d_penable[0] = 1'b0;
    repeat (3) tick();
    transfer(0, 32'h04, 1'b0, 32'h0, 0);
    check("proto_err held", 32'(proto[0]), 32'(PROT));
    presetn = 1'b0;
    tick();
    check("proto_err cleared by reset", 32'(proto[0]), 32'd0);
    presetn = 1'b1;
    tick();

    // Drain and confirm every prediction was consumed.
    for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) tick();
    check("dut0 pending expectations", 32'(q0.size()), 32'd0);
    check("dut1 pending expectations", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
